// File: rtl/bsg_node_done_monitor.sv
// bsg_node_done_monitor
// Completion monitor for the master-side node done levels. A start pulse
// opens a measurement run; each node's first done assertion is stamped with
// the run-cycle counter. When every node has reported done, the latencies
// stream out over a valid/yumi interface in ascending node order. A watchdog
// ends the run early if some node never finishes.

module bsg_node_done_monitor #(
    parameter int                nodes_p          = 1,
    parameter int                ctr_width_p      = 32,
    parameter longint unsigned   timeout_cycles_p = 64'd1048576,
    localparam int               node_id_width_lp = (nodes_p == 1) ? 1 : $clog2(nodes_p)
) (
    input  logic                        clk_i,
    input  logic                        async_reset_n_i,
    input  logic                        start_i,
    input  logic [nodes_p-1:0]          done_i,
    output logic                        busy_o,
    output logic [nodes_p-1:0]          done_mask_o,
    output logic                        report_v_o,
    output logic [node_id_width_lp-1:0] report_node_o,
    output logic [ctr_width_p-1:0]      report_cycles_o,
    input  logic                        report_yumi_i,
    output logic                        all_done_o,
    output logic                        timeout_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_REPORT  = 3'd2,
        ST_DONE    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_e;

    // Counter value seen on the last RUN cycle before the watchdog fires.
    localparam logic [ctr_width_p-1:0]      ctr_last_lp  = ctr_width_p'(timeout_cycles_p - 64'd1);
    localparam logic [node_id_width_lp-1:0] idx_last_lp  = node_id_width_lp'(nodes_p - 1);
    localparam logic [ctr_width_p-1:0]      ctr_one_lp   = ctr_width_p'(1);
    localparam logic [node_id_width_lp-1:0] idx_one_lp   = node_id_width_lp'(1);

    state_e                                  state_r;
    logic [ctr_width_p-1:0]                  ctr_r;
    logic [nodes_p-1:0]                      done_mask_r;
    logic [nodes_p-1:0][ctr_width_p-1:0]     lat_r;
    logic [node_id_width_lp-1:0]             idx_r;
    logic                                    busy_r;
    logic                                    report_v_r;
    logic [node_id_width_lp-1:0]             report_node_r;
    logic [ctr_width_p-1:0]                  report_cycles_r;
    logic                                    all_done_r;
    logic                                    timeout_r;

    logic [nodes_p-1:0][ctr_width_p-1:0]     lat_next_s;
    logic [nodes_p-1:0]                      mask_next_s;
    logic                                    all_seen_s;
    logic                                    ctr_at_limit_s;
    logic [node_id_width_lp-1:0]             idx_inc_s;
    logic [ctr_width_p-1:0]                  next_beat_s;

    // Stamp every node whose done rises this cycle with the current count.
    always_comb begin
        lat_next_s = lat_r;
        for (int i = 0; i < nodes_p; i++) begin
            if (done_i[i] && !done_mask_r[i]) begin
                lat_next_s[i] = ctr_r;
            end else begin
                lat_next_s[i] = lat_r[i];
            end
        end
    end

    // Completion/watchdog decision and the latency of the next report beat.
    always_comb begin
        mask_next_s    = done_mask_r | done_i;
        all_seen_s     = &mask_next_s;
        ctr_at_limit_s = (ctr_r == ctr_last_lp);
        idx_inc_s      = idx_r + idx_one_lp;
        next_beat_s    = '0;
        for (int i = 0; i < nodes_p; i++) begin
            next_beat_s = (idx_inc_s == node_id_width_lp'(i)) ? lat_r[i] : next_beat_s;
        end
    end

    // Run/report sequencer; all outputs are registered here.
    always_ff @(posedge clk_i or negedge async_reset_n_i) begin
        if (!async_reset_n_i) begin
            state_r         <= ST_IDLE;
            ctr_r           <= '0;
            done_mask_r     <= '0;
            lat_r           <= '0;
            idx_r           <= '0;
            busy_r          <= 1'b0;
            report_v_r      <= 1'b0;
            report_node_r   <= '0;
            report_cycles_r <= '0;
            all_done_r      <= 1'b0;
            timeout_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                    if (start_i) begin
                        state_r         <= ST_RUN;
                        ctr_r           <= '0;
                        done_mask_r     <= '0;
                        lat_r           <= '0;
                        idx_r           <= '0;
                        busy_r          <= 1'b1;
                        report_node_r   <= '0;
                        report_cycles_r <= '0;
                        all_done_r      <= 1'b0;
                        timeout_r       <= 1'b0;
                    end
                end
                ST_RUN: begin
                    lat_r       <= lat_next_s;
                    done_mask_r <= mask_next_s;
                    ctr_r       <= ctr_r + ctr_one_lp;
                    // Completion takes priority over the watchdog.
                    if (all_seen_s) begin
                        state_r         <= ST_REPORT;
                        report_v_r      <= 1'b1;
                        idx_r           <= '0;
                        report_node_r   <= '0;
                        report_cycles_r <= lat_next_s[0];
                    end else if (ctr_at_limit_s) begin
                        state_r   <= ST_TIMEOUT;
                        timeout_r <= 1'b1;
                        busy_r    <= 1'b0;
                    end
                end
                ST_REPORT: begin
                    if (report_yumi_i) begin
                        if (idx_r == idx_last_lp) begin
                            state_r    <= ST_DONE;
                            report_v_r <= 1'b0;
                            busy_r     <= 1'b0;
                            all_done_r <= 1'b1;
                        end else begin
                            idx_r           <= idx_inc_s;
                            report_node_r   <= idx_inc_s;
                            report_cycles_r <= next_beat_s;
                        end
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                    report_v_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o          = busy_r;
    assign done_mask_o     = done_mask_r;
    assign report_v_o      = report_v_r;
    assign report_node_o   = report_node_r;
    assign report_cycles_o = report_cycles_r;
    assign all_done_o      = all_done_r;
    assign timeout_o       = timeout_r;

endmodule

// File: tb/tb_bsg_node_done_monitor.sv
// Bench for bsg_node_done_monitor: 4 nodes, 100-cycle watchdog. Each run is
// described by the RUN cycle at which each node's done first rises (-1 for
// never); a reference model turns that into expected latencies, mask and
// the timeout/complete outcome.

module tb_bsg_node_done_monitor;

    localparam int NODES = 4;
    localparam int CW    = 16;
    localparam int TMO   = 100;

    typedef int vec_t [NODES];

    logic            clk = 1'b0;
    logic            async_reset_n_i = 1'b1;
    logic            start_i = 1'b0;
    logic [3:0]      done_i = 4'b0000;
    logic            busy_o;
    logic [3:0]      done_mask_o;
    logic            report_v_o;
    logic [1:0]      report_node_o;
    logic [CW-1:0]   report_cycles_o;
    logic            report_yumi_i = 1'b0;
    logic            all_done_o;
    logic            timeout_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bsg_node_done_monitor #(
        .nodes_p          (NODES),
        .ctr_width_p      (CW),
        .timeout_cycles_p (64'(TMO))
    ) dut (
        .clk_i           (clk),
        .async_reset_n_i (async_reset_n_i),
        .start_i         (start_i),
        .done_i          (done_i),
        .busy_o          (busy_o),
        .done_mask_o     (done_mask_o),
        .report_v_o      (report_v_o),
        .report_node_o   (report_node_o),
        .report_cycles_o (report_cycles_o),
        .report_yumi_i   (report_yumi_i),
        .all_done_o      (all_done_o),
        .timeout_o       (timeout_o)
    );

    // The bench must never offer yumi without a valid beat.
    always @(posedge clk) begin
        if (async_reset_n_i && report_yumi_i && !report_v_o) begin
            n_bad++;
            $display("FAIL yumi_without_valid: yumi=%b while report_v=%b", report_yumi_i, report_v_o);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a run completes on the RUN cycle of the latest first-rise,
    // provided every node rises no later than cycle TMO-1; otherwise it times
    // out after cycle TMO-1 with only the early risers captured.
    function automatic void model(input vec_t rise, output vec_t lat, output logic [3:0] mask,
                                  output bit tmo, output int end_cycle);
        int mx;
        bit all;
        mx  = 0;
        all = 1'b1;
        for (int i = 0; i < NODES; i++) begin
            lat[i] = rise[i];
            if (rise[i] < 0 || rise[i] > TMO - 1) begin
                all     = 1'b0;
                mask[i] = 1'b0;
            end else begin
                mask[i] = 1'b1;
                if (rise[i] > mx) mx = rise[i];
            end
        end
        tmo       = !all;
        end_cycle = all ? mx : TMO - 1;
    endfunction

    // Pulse start, then drive done levels for RUN cycles 0..end_cycle. After a
    // node's rise its level wanders randomly, which must not disturb capture.
    task automatic drive_run(input vec_t rise, input int end_cycle, output int busy_cnt, output int early_cnt);
        start_i = 1'b1;
        tick();
        start_i   = 1'b0;
        busy_cnt  = 0;
        early_cnt = 0;
        for (int k = 0; k <= end_cycle; k++) begin
            for (int i = 0; i < NODES; i++) begin
                if (rise[i] >= 0 && k == rise[i]) done_i[i] = 1'b1;
                else if (rise[i] >= 0 && k > rise[i]) done_i[i] = 1'($urandom_range(0, 1));
                else done_i[i] = 1'b0;
            end
            if (busy_o) busy_cnt++;
            if (timeout_o || report_v_o || all_done_o) early_cnt++;
            tick();
        end
        done_i = 4'($urandom);
    endtask

    task automatic test_reset();
        #1 async_reset_n_i = 1'b0;
        #2;
        n_cmp++;
        if ({busy_o, done_mask_o, report_v_o, report_node_o, report_cycles_o, all_done_o, timeout_o} !== '0)
            $display("FAIL reset_async: outputs=%h required 0",
                     {busy_o, done_mask_o, report_v_o, report_node_o, report_cycles_o, all_done_o, timeout_o});
        if ({busy_o, done_mask_o, report_v_o, report_node_o, report_cycles_o, all_done_o, timeout_o} !== '0) n_bad++;
        tick();
        tick();
        async_reset_n_i = 1'b1;
        done_i = 4'b1111;
        tick();
        tick();
        n_cmp++;
        if ({busy_o, done_mask_o, report_v_o, all_done_o, timeout_o} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_idle: outputs=%h required 00", {busy_o, done_mask_o, report_v_o, all_done_o, timeout_o});
        end
        done_i = 4'b0000;
    endtask

    task automatic test_staggered();
        vec_t rise = '{5, 9, 9, 20};
        vec_t lat; logic [3:0] mask; bit tmo; int endc, busy, early;
        model(rise, lat, mask, tmo, endc);
        drive_run(rise, endc, busy, early);
        n_cmp++;
        if (early !== 0 || busy !== endc + 1) begin
            n_bad++;
            $display("FAIL stag_run: early=%0d busy=%0d required 0 and %0d", early, busy, endc + 1);
        end
        for (int b = 0; b < NODES; b++) begin
            n_cmp++;
            if ({report_v_o, report_node_o, report_cycles_o} !== {1'b1, 2'(b), 16'(lat[b])}) begin
                n_bad++;
                $display("FAIL stag_beat%0d: v/node/cyc=%b/%0d/%0d required 1/%0d/%0d",
                         b, report_v_o, report_node_o, report_cycles_o, b, lat[b]);
            end
            report_yumi_i = 1'b1;
            tick();
        end
        report_yumi_i = 1'b0;
        n_cmp++;
        if ({all_done_o, busy_o, report_v_o, timeout_o} !== 4'b1000) begin
            n_bad++;
            $display("FAIL stag_done: all_done/busy/v/tmo=%b required 1000", {all_done_o, busy_o, report_v_o, timeout_o});
        end
    endtask

    task automatic test_all_high();
        vec_t rise = '{0, 0, 0, 0};
        vec_t lat; logic [3:0] mask; bit tmo; int endc, busy, early;
        model(rise, lat, mask, tmo, endc);
        drive_run(rise, endc, busy, early);
        for (int b = 0; b < NODES; b++) begin
            if (busy_o) busy++;
            n_cmp++;
            if ({report_v_o, report_node_o, report_cycles_o} !== {1'b1, 2'(b), 16'd0}) begin
                n_bad++;
                $display("FAIL allhigh_beat%0d: v/node/cyc=%b/%0d/%0d required 1/%0d/0",
                         b, report_v_o, report_node_o, report_cycles_o, b);
            end
            report_yumi_i = 1'b1;
            tick();
        end
        report_yumi_i = 1'b0;
        if (busy_o) busy++;
        n_cmp++;
        if (busy !== 5 || all_done_o !== 1'b1) begin
            n_bad++;
            $display("FAIL allhigh_busy: busy_cycles=%0d all_done=%b required 5 and 1", busy, all_done_o);
        end
    endtask

    task automatic test_timeout();
        vec_t rise;
        vec_t lat; logic [3:0] mask; bit tmo; int endc, busy, early;
        rise = '{$urandom_range(0, 99), $urandom_range(0, 99), $urandom_range(0, 99), -1};
        model(rise, lat, mask, tmo, endc);
        drive_run(rise, endc, busy, early);
        n_cmp++;
        if (early !== 0 || {timeout_o, done_mask_o, report_v_o, all_done_o, busy_o} !== {1'b1, mask, 3'b000}) begin
            n_bad++;
            $display("FAIL timeout_hit: early=%0d tmo/mask/v/ad/busy=%b required 0 and %b",
                     early, {timeout_o, done_mask_o, report_v_o, all_done_o, busy_o}, {1'b1, mask, 3'b000});
        end
        for (int c = 0; c < 5; c++) begin
            done_i = 4'($urandom);
            tick();
            n_cmp++;
            if ({timeout_o, done_mask_o, report_v_o, all_done_o} !== {1'b1, 4'b0111, 2'b00}) begin
                n_bad++;
                $display("FAIL timeout_hold: tmo/mask/v/ad=%b required 1011100", {timeout_o, done_mask_o, report_v_o, all_done_o});
            end
        end
    endtask

    task automatic test_boundary();
        vec_t rise;
        vec_t lat; logic [3:0] mask; bit tmo; int endc, busy, early;
        rise = '{$urandom_range(0, 98), $urandom_range(0, 98), $urandom_range(0, 98), 99};
        model(rise, lat, mask, tmo, endc);
        drive_run(rise, endc, busy, early);
        n_cmp++;
        if (early !== 0 || timeout_o !== 1'b0 || report_v_o !== 1'b1) begin
            n_bad++;
            $display("FAIL boundary_exit: early=%0d tmo=%b v=%b required 0/0/1", early, timeout_o, report_v_o);
        end
        for (int b = 0; b < NODES; b++) begin
            n_cmp++;
            if ({report_node_o, report_cycles_o} !== {2'(b), 16'(lat[b])}) begin
                n_bad++;
                $display("FAIL boundary_beat%0d: node/cyc=%0d/%0d required %0d/%0d", b, report_node_o, report_cycles_o, b, lat[b]);
            end
            report_yumi_i = 1'b1;
            tick();
        end
        report_yumi_i = 1'b0;
        n_cmp++;
        if ({all_done_o, timeout_o} !== 2'b10) begin
            n_bad++;
            $display("FAIL boundary_done: all_done/tmo=%b required 10", {all_done_o, timeout_o});
        end
    endtask

    task automatic test_backpressure();
        vec_t rise;
        vec_t lat; logic [3:0] mask; bit tmo; int endc, busy, early;
        rise = '{$urandom_range(0, 60), $urandom_range(0, 60), $urandom_range(0, 60), $urandom_range(0, 60)};
        model(rise, lat, mask, tmo, endc);
        drive_run(rise, endc, busy, early);
        for (int b = 0; b < NODES; b++) begin
            for (int s = 0; s < ((b == 1) ? 7 : 1); s++) begin
                n_cmp++;
                if ({report_v_o, report_node_o, report_cycles_o} !== {1'b1, 2'(b), 16'(lat[b])}) begin
                    n_bad++;
                    $display("FAIL bp_stall%0d_%0d: v/node/cyc=%b/%0d/%0d required 1/%0d/%0d",
                             b, s, report_v_o, report_node_o, report_cycles_o, b, lat[b]);
                end
                start_i = (b == 1 && s == 3);
                tick();
                start_i = 1'b0;
            end
            report_yumi_i = 1'b1;
            tick();
            report_yumi_i = 1'b0;
        end
        n_cmp++;
        if ({all_done_o, busy_o, report_v_o} !== 3'b100) begin
            n_bad++;
            $display("FAIL bp_done: all_done/busy/v=%b required 100", {all_done_o, busy_o, report_v_o});
        end
    endtask

    task automatic test_reset_mid();
        vec_t rise;
        vec_t lat; logic [3:0] mask; bit tmo; int endc, busy, early;
        rise = '{$urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 40)};
        model(rise, lat, mask, tmo, endc);
        drive_run(rise, endc, busy, early);
        report_yumi_i = 1'b1;
        tick();
        report_yumi_i = 1'b0;
        async_reset_n_i = 1'b0;
        #1;
        n_cmp++;
        if ({busy_o, done_mask_o, report_v_o, report_node_o, report_cycles_o, all_done_o, timeout_o} !== '0) begin
            n_bad++;
            $display("FAIL midreset_zero: outputs=%h required 0",
                     {busy_o, done_mask_o, report_v_o, report_node_o, report_cycles_o, all_done_o, timeout_o});
        end
        tick();
        async_reset_n_i = 1'b1;
        tick();
        rise = '{$urandom_range(41, 90), $urandom_range(41, 90), $urandom_range(41, 90), $urandom_range(41, 90)};
        model(rise, lat, mask, tmo, endc);
        drive_run(rise, endc, busy, early);
        for (int b = 0; b < NODES; b++) begin
            n_cmp++;
            if ({report_v_o, report_node_o, report_cycles_o} !== {1'b1, 2'(b), 16'(lat[b])}) begin
                n_bad++;
                $display("FAIL midreset_beat%0d: v/node/cyc=%b/%0d/%0d required 1/%0d/%0d",
                         b, report_v_o, report_node_o, report_cycles_o, b, lat[b]);
            end
            report_yumi_i = 1'b1;
            tick();
        end
        report_yumi_i = 1'b0;
    endtask

    task automatic test_random();
        vec_t rise;
        vec_t lat; logic [3:0] mask; bit tmo; int endc, busy, early;
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < NODES; i++)
                rise[i] = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 110));
            model(rise, lat, mask, tmo, endc);
            drive_run(rise, endc, busy, early);
            n_cmp++;
            if (early !== 0 || busy !== endc + 1 || timeout_o !== tmo || done_mask_o !== mask) begin
                n_bad++;
                $display("FAIL rand%0d_run: early=%0d busy=%0d tmo=%b mask=%b required 0/%0d/%b/%b",
                         r, early, busy, timeout_o, done_mask_o, endc + 1, tmo, mask);
            end
            if (!tmo) begin
                for (int b = 0; b < NODES; b++) begin
                    int st;
                    st = $urandom_range(0, 3);
                    for (int s = 0; s <= st; s++) begin
                        n_cmp++;
                        if ({report_v_o, report_node_o, report_cycles_o} !== {1'b1, 2'(b), 16'(lat[b])}) begin
                            n_bad++;
                            $display("FAIL rand%0d_beat%0d: v/node/cyc=%b/%0d/%0d required 1/%0d/%0d",
                                     r, b, report_v_o, report_node_o, report_cycles_o, b, lat[b]);
                        end
                        report_yumi_i = (s == st);
                        tick();
                        report_yumi_i = 1'b0;
                    end
                end
                n_cmp++;
                if ({all_done_o, busy_o, report_v_o} !== 3'b100) begin
                    n_bad++;
                    $display("FAIL rand%0d_done: all_done/busy/v=%b required 100", r, {all_done_o, busy_o, report_v_o});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_staggered();
        test_all_high();
        test_timeout();
        test_boundary();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bsg_node_done_monitor.md
Name: bsg_node_done_monitor

Overview:
Synthesizable completion monitor that sits downstream of the master-side guts and consumes the per-node done levels. It timestamps each node's first done assertion against a run-cycle counter, flags a watchdog timeout, and reports the per-node latencies over a valid/yumi stream. Its all_done_o/timeout_o outputs replace ad-hoc end-of-test detection.

Parameters:
nodes_p, 1, number of monitored master nodes (width of done_i)
ctr_width_p, 32, width of run counter and reported latencies
timeout_cycles_p, 1048576, run cycles before timeout; legal range 1 .. 2**ctr_width_p-1
node_id_width_lp, `BSG_SAFE_CLOG2(nodes_p), derived width of report_node_o

Ports:
clk_i  in  1  single clock for all state
async_reset_n_i  in  1  asynchronous, active-low reset
start_i  in  1  one-cycle pulse; begins a measurement run
done_i  in  nodes_p  per-node done levels (synchronous to clk_i)
busy_o  out  1  high in RUN or REPORT
done_mask_o  out  nodes_p  nodes whose done has been captured this run
report_v_o  out  1  report beat valid
report_node_o  out  node_id_width_lp  node index of current beat
report_cycles_o  out  ctr_width_p  captured latency of that node
report_yumi_i  in  1  consumer accepts beat; legal only when report_v_o=1
all_done_o  out  1  sticky: run complete and all beats reported
timeout_o  out  1  sticky: watchdog expired before all nodes done

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE; ctr=0; done_mask_o=0; latency regs=0; busy_o, report_v_o, all_done_o, timeout_o=0; report_node_o=0; report_cycles_o=0.
- States: IDLE, RUN, REPORT, DONE, TIMEOUT.
- IDLE/DONE/TIMEOUT + start_i: next cycle enters RUN. Clears ctr, done_mask_o, all_done_o, timeout_o, and latency regs.
- RUN, each cycle:
  - For every node i with done_i[i]=1 and done_mask_o[i]=0: lat[i]<=ctr; done_mask_o[i]<=1.
  - ctr<=ctr+1. The first RUN cycle has ctr=0, so a done already high at start records 0.
  - Multiple nodes rising in the same cycle all record the same ctr value.
  - done_i deasserting after capture is ignored (first-assert only).
- RUN exit:
  - If (done_mask_o | done_i) is all ones this cycle: go to REPORT next cycle.
  - Else if ctr==timeout_cycles_p-1: go to TIMEOUT. If completion and the timeout threshold fall in the same cycle, completion wins.
- start_i is ignored in RUN and REPORT.
- REPORT:
  - report_v_o=1; report_node_o=idx (starts at 0); report_cycles_o=lat[idx]. Outputs are held stable until yumi.
  - report_yumi_i=1: if idx==nodes_p-1, go to DONE, else idx<=idx+1. This gives one beat per cycle at most, nodes_p beats total, in ascending order.
  - Before the first yumi, report_v_o rises one cycle after the RUN-completion cycle.
- DONE: all_done_o=1, report_v_o=0, busy_o=0.
- TIMEOUT: timeout_o=1; done_mask_o frozen, showing the captured nodes; no report beats; busy_o=0.
- ctr never wraps: timeout_cycles_p is at most 2**ctr_width_p-1, so RUN exits before overflow.
- Reset mid-RUN or mid-REPORT: immediate return to reset values; partial report is discarded.
- report_yumi_i while report_v_o=0: ignored. The bench asserts this never occurs.
- nodes_p=1: node_id_width_lp=1, report_node_o is always 0.

Test Plan:
- nodes_p=4, timeout 100. start_i at T; done_i bits rise on RUN cycles 5,9,9,20 (nodes 0..3) -> REPORT one cycle after cycle 20. Beats are (0,5),(1,9),(2,9),(3,20) with yumi every cycle; all_done_o=1 after the 4th beat.
- done_i=4'b1111 already high at start -> all latencies 0. REPORT entered after the single RUN cycle; busy_o high for exactly that cycle plus 4 report cycles.
- Node 3 never asserts, timeout 100 -> timeout_o=1 after RUN cycle 99; done_mask_o=4'b0111; report_v_o never asserted; all_done_o=0.
- Node 3 asserts exactly on RUN cycle 99 with timeout 100 -> no timeout. Beat (3,99) is reported and all_done_o=1.
- Backpressure: yumi held low 7 cycles on beat 1 -> report_node_o=1 and report_cycles_o stable for all 7 cycles, then the sequence resumes. start_i pulsed in REPORT is ignored.
- async_reset_n_i pulsed low mid-REPORT (after beat 1) -> all outputs zero immediately. A new start_i gives a clean run with fresh latencies and no stale beats.
